serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial addition controller. One 1-bit adder cell (sum/carry logic plus
// a carry flop) is time-shared across a WIDTH-bit operand pair: operands are
// captured on an accepted start, walked LSB-first through the cell at one bit
// per clock, and the result is published with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   Defined   -> a 'sub' input exists; with sub=1 the block computes a-b
//                (b inverted at capture, carry flop seeded with 1), and
//                carry_out=1 means no borrow (a >= b unsigned).
//   Undefined -> add-only, no 'sub' port, carry flop seeded with 0.
//   Timing is identical in both builds.
//
// Parameters
//   WIDTH      operand/result width, legal 2..32 (default 8)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   a, b       in   operands, captured on the accepting edge
//   sub        in   subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse, sum/carry_out valid
//   sum        out  registered result, holds last value
//   carry_out  out  registered final carry, holds last value
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // 1-bit adder cell
  // ---------------------------------------------------------------------------
  function automatic logic cell_sum(input logic ai, input logic bi, input logic ci);
    return ai ^ bi ^ ci;
  endfunction

  function automatic logic cell_carry(input logic ai, input logic bi, input logic ci);
    return (ai & bi) | (ci & (ai ^ bi));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;     // operand A shifting out, result shifting in
  logic [WIDTH-1:0]   b_sh_q;     // operand B (possibly inverted) shifting out
  logic [CNT_W-1:0]   cnt_q;      // index of the bit processed on the next edge
  logic               c_q;        // carry flop of the shared cell
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------------
  logic               bit_sum_d;
  logic               bit_carry_d;
  logic [WIDTH-1:0]   res_shift_d;
  logic [WIDTH-1:0]   b_shift_d;
  logic               last_bit_d;
  logic [WIDTH-1:0]   b_load_d;
  logic               c_init_d;

  always_comb begin
    bit_sum_d   = cell_sum(a_sh_q[0], b_sh_q[0], c_q);
    bit_carry_d = cell_carry(a_sh_q[0], b_sh_q[0], c_q);
    // The A register doubles as the result register: each consumed operand
    // bit leaves from the LSB while the new sum bit enters at the MSB, so
    // after WIDTH shifts it holds the full result in natural bit order.
    res_shift_d = {bit_sum_d, a_sh_q[WIDTH-1:1]};
    b_shift_d   = {1'b0, b_sh_q[WIDTH-1:1]};
    last_bit_d  = (cnt_q == LAST_BIT);
  end

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1, the +1 entering as initial carry.
  always_comb begin
    b_load_d = sub ? ~b : b;
    c_init_d = sub;
  end
`else
  always_comb begin
    b_load_d = b;
    c_init_d = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            c_q     <= c_init_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          a_sh_q <= res_shift_d;
          b_sh_q <= b_shift_d;
          c_q    <= bit_carry_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_bit_d) begin
            // Results are published only here, so sum/carry_out stay
            // frozen for the whole of RUN.
            sum_q   <= res_shift_d;
            cout_q  <= bit_carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(busy_q && done_q));
  a_done_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);
  a_busy_is_run    : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q == S_RUN));
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected held result (what sum/carry_out must show outside of DONE edges)
  logic [W-1:0] last_sum;
  logic         last_cout;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction starting from IDLE, checking the whole cycle profile.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] es, input logic ec, input string tag);
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);             // accepting edge k
    @(negedge clk);
    start = 1'b0;
    a     = ~va;                // must not disturb the captured operands
    b     = ~vb;
    for (int j = 0; j < W; j++) begin
      check($sformatf("%s busy[%0d]", tag, j), 32'(busy), 32'd1);
      check($sformatf("%s done[%0d]", tag, j), 32'(done), 32'd0);
      check($sformatf("%s sum_hold[%0d]", tag, j), 32'(sum), 32'(last_sum));
      check($sformatf("%s cout_hold[%0d]", tag, j), 32'(carry_out), 32'(last_cout));
      @(negedge clk);
    end
    check($sformatf("%s done", tag), 32'(done), 32'd1);
    check($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
    check($sformatf("%s sum", tag), 32'(sum), 32'(es));
    check($sformatf("%s carry_out", tag), 32'(carry_out), 32'(ec));
    last_sum  = es;
    last_cout = ec;
    @(negedge clk);
    check($sformatf("%s done_cleared", tag), 32'(done), 32'd0);
    check($sformatf("%s busy_idle", tag), 32'(busy), 32'd0);
    check($sformatf("%s sum_after", tag), 32'(sum), 32'(es));
  endtask

  initial begin
    tbl[0]  = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    tbl[3]  = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    tbl[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[8]  = '{8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1};
    tbl[9]  = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
    tbl[10] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
    tbl[11] = '{8'h9C, 8'h9C, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    last_sum  = '0;
    last_cout = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst carry_out", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no start busy", 32'(busy), 32'd0);

    // Table-driven transactions (back-to-back requests included)
    for (int i = 0; i < 12; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      sub = tbl[i].vsub;
`else
      if (tbl[i].vsub) continue;
`endif
      run_op(tbl[i].va, tbl[i].vb, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));
    end
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif

    // start held high, operands zeroed during RUN
    @(negedge clk);
    a     = 8'h3C;
    b     = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h00;
    b = 8'h00;
    for (int j = 0; j <= 2 * W + 3; j++) begin
      check($sformatf("held busy[%0d]", j), 32'(busy),
            32'((j < W) || (j >= W + 2 && j < 2 * W + 2)));
      check($sformatf("held done[%0d]", j), 32'(done),
            32'((j == W) || (j == 2 * W + 2)));
      if (j == W) begin
        check("held first sum", 32'(sum), 32'h4B);
        check("held first cout", 32'(carry_out), 32'd0);
      end
      if (j == W + 2) start = 1'b0;
      if (j == 2 * W + 2) begin
        check("held second sum", 32'(sum), 32'h00);
        check("held second cout", 32'(carry_out), 32'd0);
      end
      @(negedge clk);
    end
    last_sum  = 8'h00;
    last_cout = 1'b0;

    // Asynchronous reset in the middle of RUN
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "pre_rst");
    @(negedge clk);
    a     = 8'h3C;
    b     = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);   // bits 0..3 processed, bit 4 next
    check("midrun busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst sum", 32'(sum), 32'd0);
    check("async rst cout", 32'(carry_out), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("in rst done[%0d]", j), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    last_sum  = '0;
    last_cout = 1'b0;
    for (int j = 0; j < W + 2; j++) begin
      @(negedge clk);
      check($sformatf("post rst no done[%0d]", j), 32'(done), 32'd0);
      check($sformatf("post rst idle[%0d]", j), 32'(busy), 32'd0);
    end
    run_op(8'h3C, 8'h0F, 8'h4B, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
